seq_alu: RTL

Parametrised, handshaked successor to the single-cycle ALU, used as the execute unit behind the instruction decoder.
- Logic, shift, rotate, add/sub and compare ops complete in 1 cycle.
- MUL and DIV are iterative: shift-add multiply and restoring divide, one bit per cycle.
- Produces a double-width result (high half or remainder) and status flags.
- Uses valid/ready on both input and output, so it can stall against memory writeback.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/seq_alu_muldiv.sv | 63 ++++++
 rtl/seq_alu.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, flag bit
// positions and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    localparam int FLG_Z  = 0;
    localparam int FLG_N  = 1;
    localparam int FLG_C  = 2;
    localparam int FLG_V  = 3;
    localparam int FLG_DZ = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef logic [4:0] flags_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per cycle.
// lo/hi show the value after the current step, so they are final while done is high.
module seq_alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;
    logic                 is_div;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_part;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, dividend bits shifting into quotient}.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    assign div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = (div_part >= {1'b0, opb});
    assign div_rem  = div_ge ? (div_part[WIDTH-1:0] - opb) : div_part[WIDTH-1:0];
    assign div_next = {div_rem, acc[WIDTH-2:0], div_ge};

    assign step = is_div ? div_next : mul_next;
    assign done = (count == CW'(1));
    assign lo   = step[WIDTH-1:0];
    assign hi   = step[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
        end else if (start) begin
            count  <= CW'(WIDTH);
            acc    <= {{WIDTH{1'b0}}, a};
            opb    <= b;
            is_div <= div;
        end else if (count != '0) begin
            acc   <= step;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute unit: single-cycle logic/shift/add/compare ops plus
// iterative MUL/DIV, with double-width result and status flags.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] WIDTH_L = (SHW+1)'(WIDTH);

    logic [1:0]       state;
    logic             accept;
    logic             div_zero;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [SHW-1:0]   sh;
    logic [SHW:0]     rsh;
    logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w;
    logic [WIDTH-1:0] comb_res, comb_hi;
    logic             comb_c, comb_v;
    flags_t           comb_flags, md_flags;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign div_zero  = (operand2 == '0);
    assign md_start  = accept && ((opcode == OP_MUL) || ((opcode == OP_DIV) && !div_zero));

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .div   (opcode == OP_DIV),
        .a     (operand1),
        .b     (operand2),
        .done  (md_done),
        .lo    (md_lo),
        .hi    (md_hi)
    );

    // Extra top bit on shifts catches the last bit shifted out (0 for a zero shift).
    assign sh     = operand2[SHW-1:0];
    assign rsh    = WIDTH_L - {1'b0, sh};
    assign sum_w  = {1'b0, operand1} + {1'b0, operand2};
    assign diff_w = {1'b0, operand1} - {1'b0, operand2};
    assign shl_w  = {1'b0, operand1} << sh;
    assign shr_w  = {operand1, 1'b0} >> sh;

    always_comb begin
        comb_res = '0;
        comb_hi  = '0;
        comb_c   = 1'b0;
        comb_v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                comb_res = sum_w[WIDTH-1:0];
                comb_c   = sum_w[WIDTH];
                comb_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                           (sum_w[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB: begin
                comb_res = diff_w[WIDTH-1:0];
                comb_c   = diff_w[WIDTH];
                comb_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                           (diff_w[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_DIV: begin
                if (div_zero) begin
                    comb_res = '1;
                    comb_hi  = operand1;
                end
            end
            OP_SHL: begin
                comb_res = shl_w[WIDTH-1:0];
                comb_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                comb_res = shr_w[WIDTH:1];
                comb_c   = shr_w[0];
            end
            OP_ROL:  comb_res = (operand1 << sh) | (operand1 >> rsh);
            OP_ROR:  comb_res = (operand1 >> sh) | (operand1 << rsh);
            OP_AND:  comb_res = operand1 & operand2;
            OP_OR:   comb_res = operand1 | operand2;
            OP_XOR:  comb_res = operand1 ^ operand2;
            OP_NOR:  comb_res = ~(operand1 | operand2);
            OP_NAND: comb_res = ~(operand1 & operand2);
            OP_XNOR: comb_res = ~(operand1 ^ operand2);
            OP_GT:   comb_res = {{(WIDTH-1){1'b0}}, (operand1 > operand2)};
            OP_EQ:   comb_res = {{(WIDTH-1){1'b0}}, (operand1 == operand2)};
            default: ;
        endcase
    end

    always_comb begin
        comb_flags         = '0;
        comb_flags[FLG_Z]  = (comb_res == '0);
        comb_flags[FLG_N]  = comb_res[WIDTH-1];
        comb_flags[FLG_C]  = comb_c;
        comb_flags[FLG_V]  = comb_v;
        comb_flags[FLG_DZ] = (opcode == OP_DIV) && div_zero;

        md_flags           = '0;
        md_flags[FLG_Z]    = (md_lo == '0);
        md_flags[FLG_N]    = md_lo[WIDTH-1];
        md_flags[FLG_C]    = (state == ST_MUL) && (md_hi != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (opcode == OP_MUL) begin
                            state <= ST_MUL;
                        end else if ((opcode == OP_DIV) && !div_zero) begin
                            state <= ST_DIV;
                        end else begin
                            state     <= ST_DONE;
                            result    <= comb_res;
                            result_hi <= comb_hi;
                            flags     <= comb_flags;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_done) begin
                        state     <= ST_DONE;
                        result    <= md_lo;
                        result_hi <= md_hi;
                        flags     <= md_flags;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
